// File: rtl/mpu_link_pkg.sv
// Shared widths, FSM state type and helpers for the MPU host link.
package mpu_link_pkg;

  localparam int INSTR_W   = 32;
  localparam int DATA_W    = 16;
  localparam int RSP_CNT_W = 5;
  localparam int OPC_HI    = 31;
  localparam int OPC_LO    = 28;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT
  } state_t;

  // Clamp a requested response count to the largest legal value.
  function automatic logic [RSP_CNT_W-1:0] sat_rsp(input logic [RSP_CNT_W-1:0] req,
                                                   input int max_rsp);
    return (int'(req) > max_rsp) ? RSP_CNT_W'(max_rsp) : req;
  endfunction

endpackage

// File: rtl/mpu_host_link_if.sv
// Host command/response port and MPU issue/return pair of the host link.
interface mpu_host_link_if
  import mpu_link_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH = 16
) ();

  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [INSTR_W-1:0]   cmd_instr;
  logic [RSP_CNT_W-1:0] cmd_rsp_words;
  logic [INSTR_W-1:0]   instruction_out;
  logic                 receive_out;
  logic [DATA_W-1:0]    mpu_data_in;
  logic                 mpu_send;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic [CNT_W-1:0]     rsp_count;

  modport slave (
    input  cmd_valid, cmd_instr, cmd_rsp_words, mpu_data_in, mpu_send, rsp_ready,
    output cmd_ready, instruction_out, receive_out, rsp_valid, rsp_data, rsp_count
  );

  modport master (
    output cmd_valid, cmd_instr, cmd_rsp_words, mpu_data_in, mpu_send, rsp_ready,
    input  cmd_ready, instruction_out, receive_out, rsp_valid, rsp_data, rsp_count
  );

endinterface

// File: rtl/mpu_rsp_fifo.sv
// First-word-fall-through response FIFO; DEPTH must be a power of two.
module mpu_rsp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mpu_host_link.sv
// Host-side issuer for the MPU: pulses one instruction into the MPU and
// collects the expected result words into a response FIFO.
module mpu_host_link
  import mpu_link_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RSP        = 25
) (
  input  logic            clock,
  input  logic            reset_n,
  mpu_host_link_if.slave  bus,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_overflow,
  output logic            err_spurious
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state;
  logic [RSP_CNT_W-1:0] remaining;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign fifo_push     = (state == WAIT) && bus.mpu_send;
  assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = !fifo_empty;

  mpu_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data (bus.mpu_data_in),
    .pop     (fifo_pop),
    .rd_data (bus.rsp_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (bus.rsp_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      remaining           <= '0;
      tmo_cnt             <= '0;
      bus.cmd_ready       <= 1'b0;
      bus.instruction_out <= '0;
      bus.receive_out     <= 1'b0;
      busy                <= 1'b0;
      err_timeout         <= 1'b0;
      err_overflow        <= 1'b0;
      err_spurious        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.instruction_out <= bus.cmd_instr;
            remaining           <= sat_rsp(bus.cmd_rsp_words, MAX_RSP);
            err_timeout         <= 1'b0;
            err_overflow        <= 1'b0;
            err_spurious        <= 1'b0;
            bus.receive_out     <= 1'b1;
            bus.cmd_ready       <= 1'b0;
            busy                <= 1'b1;
            state               <= ISSUE;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          bus.receive_out <= 1'b0;
          state           <= HOLD;
        end
        HOLD: begin
          if (remaining == '0) begin
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            tmo_cnt <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mpu_send) begin
            remaining <= remaining - RSP_CNT_W'(1);
            tmo_cnt   <= '0;
            if (fifo_full && !fifo_pop) err_overflow <= 1'b1;
            if (remaining == RSP_CNT_W'(1)) begin
              bus.cmd_ready <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Outstanding words are abandoned; late arrivals count as spurious.
            err_timeout   <= 1'b1;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the case so a stray word wins over the accept-time clear.
      if (bus.mpu_send && (state != WAIT)) err_spurious <= 1'b1;
    end
  end

endmodule

// File: doc/mpu_host_link.md
# mpu_host_link

Host-side issuer for the matrix processor unit (`mpu`). Accepts one 32-bit instruction at a time from a host command port and drives the MPU's `instruction_in`/`receive` pair with a clean single-cycle pulse. It then collects the expected number of 16-bit result words that the MPU returns on `data_out`/`send`, and presents them to the host through a response FIFO. Errors are flagged on timeout, overflow, or unexpected words.

## Interface
- `RSP_FIFO_DEPTH`, 16: response FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT_CYCLES`, 1024: maximum idle cycles between response words in WAIT.
- `MAX_RSP`, 25: largest legal `cmd_rsp_words`.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_instr`  in  32  instruction to issue (opcode in [31:28]).
- `cmd_rsp_words`  in  5  result words to expect (0..MAX_RSP).
- `instruction_out`  out  32  to MPU `instruction_in`.
- `receive_out`  out  1  to MPU `receive`.
- `mpu_data_in`  in  16  from MPU `data_out`.
- `mpu_send`  in  1  from MPU `send`; one word per high cycle.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  host pops the head.
- `rsp_data`  out  16  FIFO head word.
- `busy`  out  1  state ≠ IDLE.
- `err_timeout`, `err_overflow`, `err_spurious`  out  1 each  sticky error flags.

## Operation
- FSM states: IDLE → ISSUE → HOLD → WAIT → IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`:
  - latch `cmd_instr` into `instruction_out`;
  - latch `cmd_rsp_words` into the remaining-count register;
  - clear all three error flags;
  - go to ISSUE.
- ISSUE: `receive_out`=1 for exactly this one cycle, then go to HOLD.
- HOLD: `receive_out`=0 (guaranteed low gap).
  - If remaining count = 0, go to IDLE.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT: each cycle with `mpu_send`=1:
  - push `mpu_data_in` into the FIFO;
  - decrement the remaining count;
  - reset the timeout counter.
  - When the count reaches 0, go to IDLE.
- WAIT without a word: increment the timeout counter. On reaching TIMEOUT_CYCLES, set `err_timeout` and go to IDLE; any words still outstanding are abandoned.
- `instruction_out` holds its value until the next accepted command.
- Word arriving while FIFO is full and not popping the same cycle: the word is dropped but still counted; `err_overflow` is set.
- `mpu_send`=1 in IDLE, ISSUE or HOLD: word is dropped and `err_spurious` is set.
- `cmd_rsp_words` > MAX_RSP: saturated to MAX_RSP.
- FIFO behaviour:
  - first-word-fall-through;
  - pop when `rsp_valid`&&`rsp_ready`;
  - push and pop in the same cycle while full is accepted, and occupancy is unchanged;
  - the FIFO is not cleared between commands.

## Timing
- Reset values, held while `reset_n`=0:
  - `cmd_ready`=0, `instruction_out`=0, `receive_out`=0, `rsp_valid`=0, `busy`=0, all error flags 0;
  - FIFO empty, state IDLE.
- `cmd_ready` is registered and goes to 1 on the first rising edge after `reset_n` is released.
- Command accepted at edge T:
  - edge T+1: `instruction_out` valid and `receive_out`=1;
  - edge T+2: `receive_out`=0;
  - edge T+3: in WAIT, or in IDLE with `cmd_ready`=1 if 0 words were requested.
- Word sampled at edge E → `rsp_valid`/`rsp_data` valid after E (1-cycle latency into an empty FIFO).
- Last word sampled at edge E → `cmd_ready`=1 after E, so a new command can be accepted at E+1.
- Timeout: with no words in WAIT, `err_timeout` and `cmd_ready` assert TIMEOUT_CYCLES cycles after entering WAIT.
- Asynchronous reset mid-operation:
  - `receive_out` drops immediately;
  - FIFO is flushed;
  - no partial state survives.

## Structure
- Package `mpu_link_pkg`:
  - state enum (IDLE, ISSUE, HOLD, WAIT);
  - INSTR_W=32, DATA_W=16, RSP_CNT_W=5;
  - opcode field bounds [31:28].
- Sub-module `mpu_rsp_fifo`:
  - parameterised DEPTH/WIDTH;
  - FWFT with full/empty and a count of width clog2(DEPTH+1).
- The top level holds the FSM, remaining-word counter, timeout counter and error flags.

## Test plan
- Reset and first command:
  - stimulus: release reset, then issue `cmd_instr`=0x6490A090 with `cmd_rsp_words`=0;
  - expect `receive_out` high for exactly one cycle at T+1, `instruction_out`=0x6490A090, and `cmd_ready`=1 at T+3.
- Load with results:
  - stimulus: `cmd_instr`=0x74900000, `cmd_rsp_words`=4; MPU returns 0x0001, 0x0002, 0x0003, 0x0004 on non-consecutive cycles;
  - expect the FIFO to yield them in order, `busy` to drop after the 4th word, and no errors.
- Timeout:
  - stimulus: TIMEOUT_CYCLES=16, `cmd_rsp_words`=3, only 1 word sent;
  - expect `err_timeout`=1 and `cmd_ready`=1 16 cycles after the last word; exactly 1 word in the FIFO.
- Overflow:
  - stimulus: depth 16, `rsp_ready`=0, `cmd_rsp_words`=20, 20 words sent;
  - expect 16 words stored, `err_overflow`=1, and return to IDLE after the 20th word.
- Spurious word and reset:
  - stimulus 1: `mpu_send` pulsed in IDLE; expect `err_spurious`=1 and FIFO unchanged;
  - stimulus 2: assert `reset_n` low mid-WAIT; expect all outputs 0 immediately and an empty FIFO.
